// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared constants and types for the register-file writeback path.
//   DW     : register data width
//   AW     : register address width
//   gnt_e  : which requester owns the write port in a given cycle
// Also intended for reuse by the forwarding unit.
// ---------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_MEM  = 2'd1,
    GNT_ALU  = 2'd2
  } gnt_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small synchronous FIFO of (rd, data) writeback entries. Besides the usual
// head/count view it exposes every slot's rd and a per-slot valid bit so the
// hazard logic can compare decode sources against all queued destinations.
// Ports:
//   clk, rst_n           : clock, async active-low reset (empties the FIFO)
//   push/push_rd/_data   : enqueue an entry at posedge
//   pop                  : dequeue the head at posedge
//   head_rd/head_data    : oldest entry (meaningful when cnt != 0)
//   cnt                  : occupancy, 0..DEPTH
//   ent_valid/ent_rd     : per-slot occupancy flag and destination register
// ---------------------------------------------------------------------------
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = regfile_wb_arbiter_pkg::DW,
  parameter int AW    = regfile_wb_arbiter_pkg::AW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [AW-1:0]                push_rd,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic [AW-1:0]                head_rd,
  output logic [DW-1:0]                head_data,
  output logic [$clog2(DEPTH):0]       cnt,
  output logic [DEPTH-1:0]             ent_valid,
  output logic [DEPTH-1:0][AW-1:0]     ent_rd
);
  import regfile_wb_arbiter_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_mem_q   [DEPTH];
  logic [AW-1:0] rd_mem_d   [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [DW-1:0] data_mem_d [DEPTH];

  // Next-state for pointers, count and storage. Pointers are PW bits wide so
  // they wrap modulo DEPTH on their own (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = push_rd;
      data_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset empties the FIFO and clears the storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  // Slot i holds live data when its distance from the read pointer (modulo
  // DEPTH) is below the occupancy.
  always_comb begin
    logic [PW-1:0] offset;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PW'(i) - rd_ptr_q;
      ent_valid[i] = ({1'b0, offset} < cnt_q);
      ent_rd[i]    = rd_mem_q[i];
    end
  end

  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign cnt       = cnt_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between the memory/load stage
// (priority) and the ALU (queued in a small FIFO, with a starvation guard),
// and raises a read-after-write stall to decode for uncommitted writes.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   alu_valid/alu_rd/alu_data    : ALU writeback request
//   alu_ready                    : ALU FIFO has room (state only)
//   mem_valid/mem_rd/mem_data    : memory writeback request
//   mem_ready                    : memory request accepted this cycle
//   wr_en/wr_addr/wr_data        : registered write to the register file
//   rs_addr/rt_addr              : decode source registers
//   hz_stall                     : decode must hold
//   alu_cnt                      : ALU FIFO occupancy
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int ALU_DEPTH  = 2,
  parameter int STARVE_MAX = 3,
  parameter int DW         = regfile_wb_arbiter_pkg::DW,
  parameter int AW         = regfile_wb_arbiter_pkg::AW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  input  logic [AW-1:0]               alu_rd,
  input  logic [DW-1:0]               alu_data,
  output logic                        alu_ready,
  input  logic                        mem_valid,
  input  logic [AW-1:0]               mem_rd,
  input  logic [DW-1:0]               mem_data,
  output logic                        mem_ready,
  output logic                        wr_en,
  output logic [AW-1:0]               wr_addr,
  output logic [DW-1:0]               wr_data,
  input  logic [AW-1:0]               rs_addr,
  input  logic [AW-1:0]               rt_addr,
  output logic                        hz_stall,
  output logic [$clog2(ALU_DEPTH):0]  alu_cnt
);
  import regfile_wb_arbiter_pkg::*;

  localparam int CW = $clog2(ALU_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  gnt_e                      gnt;
  logic                      alu_acc;
  logic                      alu_pend;
  logic                      force_alu;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [AW-1:0]             head_rd;
  logic [DW-1:0]             head_data;
  logic [ALU_DEPTH-1:0]      ent_valid;
  logic [ALU_DEPTH-1:0][AW-1:0] ent_rd;
  logic [AW-1:0]             sel_rd;
  logic [DW-1:0]             sel_data;
  logic [SW-1:0]             starve_cnt_q, starve_cnt_d;
  logic                      wr_en_q, wr_en_d;
  logic [AW-1:0]             wr_addr_q, wr_addr_d;
  logic [DW-1:0]             wr_data_q, wr_data_d;
  logic                      rs_hit, rt_hit;

  wb_fifo #(
    .DEPTH (ALU_DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_rd   (alu_rd),
    .push_data (alu_data),
    .pop       (fifo_pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .cnt       (alu_cnt),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  assign fifo_empty = (alu_cnt == '0);
  assign alu_ready  = (alu_cnt < CW'(ALU_DEPTH));
  assign alu_acc    = alu_valid && alu_ready;
  assign alu_pend   = !fifo_empty || alu_valid;
  assign force_alu  = (starve_cnt_q == SW'(STARVE_MAX)) && alu_pend;
  assign mem_ready  = !force_alu;

  // Grant and candidate selection. The ALU candidate is the FIFO head when
  // one exists; otherwise the incoming result bypasses the FIFO. Any accepted
  // ALU result that does not go out this cycle is queued behind the head.
  always_comb begin
    gnt      = GNT_NONE;
    fifo_pop = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (force_alu) begin
      gnt = GNT_ALU;
    end else if (mem_valid) begin
      gnt = GNT_MEM;
    end else if (alu_pend) begin
      gnt = GNT_ALU;
    end
    case (gnt)
      GNT_MEM: begin
        sel_rd   = mem_rd;
        sel_data = mem_data;
      end
      GNT_ALU: begin
        if (!fifo_empty) begin
          sel_rd   = head_rd;
          sel_data = head_data;
          fifo_pop = 1'b1;
        end else begin
          sel_rd   = alu_rd;
          sel_data = alu_data;
        end
      end
      default: ;
    endcase
    fifo_push = alu_acc && !((gnt == GNT_ALU) && fifo_empty);
  end

  // Output register and starvation counter next state. An rd=0 grant still
  // uses the slot but never raises the write enable. Address/data hold on an
  // idle cycle since wr_en is low anyway.
  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    starve_cnt_d = starve_cnt_q;
    if (gnt != GNT_NONE) begin
      wr_en_d   = (sel_rd != '0);
      wr_addr_d = sel_rd;
      wr_data_d = sel_data;
    end
    if ((gnt == GNT_ALU) || !alu_pend) begin
      starve_cnt_d = '0;
    end else if ((gnt == GNT_MEM) && (starve_cnt_q != SW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Registered state; reset drops any pending write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Hazard detect: a source is unsafe while its register is queued, being
  // pushed this cycle, or in the write register (the register file only
  // commits at the negedge, so first-half reads are still stale).
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < ALU_DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == rs_addr)) rs_hit = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == rt_addr)) rt_hit = 1'b1;
    end
    if (wr_en_q && (wr_addr_q == rs_addr)) rs_hit = 1'b1;
    if (wr_en_q && (wr_addr_q == rt_addr)) rt_hit = 1'b1;
    if (fifo_push && (alu_rd == rs_addr)) rs_hit = 1'b1;
    if (fifo_push && (alu_rd == rt_addr)) rt_hit = 1'b1;
    hz_stall = ((rs_addr != '0) && rs_hit) || ((rt_addr != '0) && rt_hit);
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
